logic_gate_unit: RTL and testbench
==================================

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, legal range 1..64.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid  input  1  the request is present.
REQ-005 SHALL have port in_ready  output  1  the unit accepts the request this cycle.
REQ-006 SHALL have port in_a  input  WIDTH  operand A.
REQ-007 SHALL have port in_b  input  WIDTH  operand B.
REQ-008 SHALL have port in_op  input  3  the operation: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A.
REQ-009 SHALL have port in_sweep  input  1  generate the 4-row truth table of in_op instead of evaluating in_a/in_b.
REQ-010 SHALL have port out_valid  output  1  the result is present.
REQ-011 SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-012 SHALL have port out_y  output  WIDTH  the result.
REQ-013 SHALL have port out_row  output  2  the truth-table row {A,B}; 0 for non-sweep results.
REQ-014 SHALL have port out_last  output  1  the final beat of a transaction.

Function
REQ-015 Accept = in_valid && in_ready; output handshake = out_valid && out_ready.
REQ-016 in_ready SHALL be (state==IDLE) && (!out_valid || out_ready); it is combinational from state and out_ready only.
REQ-017 A non-sweep accept SHALL load out_y = op(in_a,in_b) bitwise, out_row=0, out_last=1, and out_valid=1 on the next edge (latency 1 cycle).
REQ-018 A single output register SHALL allow one result per cycle back-to-back when out_ready is held high.
REQ-019 While out_valid=1 and out_ready=0, out_y/out_row/out_last SHALL hold stable.
REQ-020 An output handshake with no accept in the same cycle SHALL clear out_valid; a simultaneous handshake and accept SHALL reload the register.
REQ-021 The FSM SHALL have states IDLE and SWEEP, plus a 2-bit row counter and a latched 3-bit op.
REQ-022 A sweep accept SHALL latch in_op, load row 0 (A=0,B=0 replicated across all WIDTH bits) with out_last=0, set row=1, and go IDLE->SWEEP.
REQ-023 In SWEEP, each output handshake SHALL load the next row (A=row[1], B=row[0]) and increment row.
REQ-024 Loading row 3 SHALL set out_last=1 and return to IDLE in the same edge; in_ready rises once row 3 drains.
REQ-025 in_a, in_b, in_op and in_sweep SHALL be ignored while in SWEEP.
REQ-026 The ops NOT A and PASS A SHALL ignore B in both modes.

Reset
REQ-027 rst=1 SHALL force state=IDLE, row=0, out_valid=0, out_y=0, out_row=0, and out_last=0 on the next edge, including mid-sweep; the partial sweep is discarded.
REQ-028 During the reset cycle, in_ready SHALL be driven 0.

Structure
REQ-029 Package logic_gate_pkg SHALL hold the op enum (3-bit, 8 codes), the state enum, and the row width constant.
REQ-030 Sub-module gate_eval (purely combinational; WIDTH-parameterised; inputs a, b, op; output y) SHALL be instantiated once and shared by both modes.

Verification
REQ-031 WIDTH=8, op=NAND, a=8'hF0, b=8'hCC, out_ready=1 -> next cycle out_y=8'h3F, out_last=1, out_row=0.
REQ-032 Sweep with op=NAND, out_ready=1 -> 4 consecutive beats with out_y=FF,FF,FF,00, out_row=0,1,2,3, out_last only on row 3, in_ready=0 throughout.
REQ-033 Sweep with op=XOR and out_ready toggled 1/0 -> beats 00,FF,FF,00, each held stable while stalled, with no row skipped or duplicated.
REQ-034 Eight back-to-back non-sweep requests (all ops, a=8'hA5, b=8'h3C), out_ready=1 -> one result per cycle: 24,BD,DB,42,99,66,5A,A5.
REQ-035 rst asserted while out_row=2 of a sweep -> next cycle out_valid=0, in_ready=0; the cycle after, in_ready=1 and a new request is processed normally.
REQ-036 out_valid=1, out_ready=0, in_valid=1 -> in_ready=0 and no accept; set out_ready=1 -> handshake and accept occur in the same cycle and the new result appears next cycle.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared types and constants for the logic gate unit: operation codes,
// sweep FSM states and the truth-table row counter width.
package logic_gate_pkg;

  localparam int ROW_W = 2;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/logic_gate_unit_gate_eval.sv
// Purely combinational bitwise gate evaluator, shared by the direct
// evaluation path and the truth-table sweep path.
module gate_eval
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  // Select the bitwise function; NOT A and PASS A ignore b entirely.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Logic gate unit: evaluates one bitwise op per request with a single
// registered output, or streams the 4-row truth table of an op when a
// sweep is requested. Valid/ready handshakes on both sides.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_sweep,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [ROW_W-1:0] out_row,
  output logic             out_last
);

  state_e           r_state, w_state_n;
  logic [ROW_W-1:0] r_row,   w_row_n;
  op_e              r_op,    w_op_n;

  logic             r_valid;
  logic [WIDTH-1:0] r_y;
  logic [ROW_W-1:0] r_out_row;
  logic             r_last;

  logic             w_accept;
  logic             w_hs;
  logic             w_load;
  logic             w_clear;
  logic [ROW_W-1:0] w_load_row;
  logic             w_load_last;
  logic [WIDTH-1:0] w_eval_a;
  logic [WIDTH-1:0] w_eval_b;
  op_e              w_eval_op;
  logic [WIDTH-1:0] w_eval_y;

  // The output register frees up either when empty or when draining this
  // cycle; new requests are refused while a sweep is streaming or in reset.
  assign in_ready  = (r_state == ST_IDLE) && (!r_valid || out_ready) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_hs      = r_valid && out_ready;

  assign out_valid = r_valid;
  assign out_y     = r_y;
  assign out_row   = r_out_row;
  assign out_last  = r_last;

  gate_eval #(.WIDTH(WIDTH)) u_gate_eval (
    .a  (w_eval_a),
    .b  (w_eval_b),
    .op (w_eval_op),
    .y  (w_eval_y)
  );

  // Next-state logic: picks evaluator operands and decides when the output
  // register loads (new result or next row) or empties.
  always_comb begin
    w_state_n   = r_state;
    w_row_n     = r_row;
    w_op_n      = r_op;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_load_row  = '0;
    w_load_last = 1'b0;
    w_eval_a    = in_a;
    w_eval_b    = in_b;
    w_eval_op   = op_e'(in_op);
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (in_sweep) begin
            // Row 0 is A=0, B=0 on every bit; the op is captured for later rows.
            w_eval_a    = '0;
            w_eval_b    = '0;
            w_op_n      = op_e'(in_op);
            w_row_n     = ROW_W'(1);
            w_load_last = 1'b0;
            w_state_n   = ST_SWEEP;
          end else begin
            w_load_last = 1'b1;
          end
        end else if (w_hs) begin
          w_clear = 1'b1;
        end
      end
      ST_SWEEP: begin
        // Inputs are ignored here; rows come from the counter and latched op.
        w_eval_a  = {WIDTH{r_row[1]}};
        w_eval_b  = {WIDTH{r_row[0]}};
        w_eval_op = r_op;
        if (w_hs) begin
          w_load     = 1'b1;
          w_load_row = r_row;
          w_row_n    = r_row + ROW_W'(1);
          if (r_row == ROW_W'(3)) begin
            w_load_last = 1'b1;
            w_row_n     = '0;
            w_state_n   = ST_IDLE;
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // FSM state, row counter and latched sweep op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_op    <= OP_AND;
    end else begin
      r_state <= w_state_n;
      r_row   <= w_row_n;
      r_op    <= w_op_n;
    end
  end

  // Single output register: reloads on any load, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_y       <= '0;
      r_out_row <= '0;
      r_last    <= 1'b0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_y       <= w_eval_y;
      r_out_row <= w_load_row;
      r_last    <= w_load_last;
    end else if (w_clear) begin
      r_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit: stimulus pushes hand-computed
// expected beats, a negedge monitor pops and compares on each handshake
// and checks that stalled outputs hold stable.
module tb_logic_gate_unit;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] y;
    logic [1:0]   row;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         in_sweep;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic [1:0]   out_row;
  logic         out_last;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  logic         hold = 1'b0;
  logic [W-1:0] hy;
  logic [1:0]   hrow;
  logic         hlast;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic_gate_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_sweep  (in_sweep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_row   (out_row),
    .out_last  (out_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] y, input logic [1:0] row, input logic last);
    exp_t e;
    e.y = y; e.row = row; e.last = last;
    q.push_back(e);
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic send(input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic sw);
    int t;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_sweep = sw;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each handshaked beat against the scoreboard head and
  // verify the output holds while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (hold) begin
        chk("hold_y",    64'(out_y),    64'(hy));
        chk("hold_row",  64'(out_row),  64'(hrow));
        chk("hold_last", 64'(out_last), 64'(hlast));
      end
      if (out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'(out_y), 64'hdead);
        end else begin
          e = q.pop_front();
          chk("beat_y",    64'(out_y),    64'(e.y));
          chk("beat_row",  64'(out_row),  64'(e.row));
          chk("beat_last", 64'(out_last), 64'(e.last));
        end
        hold = 1'b0;
      end else begin
        hold = 1'b1; hy = out_y; hrow = out_row; hlast = out_last;
      end
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int t;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_sweep = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_y",     64'(out_y),     64'd0);
    chk("rst_out_row",   64'(out_row),   64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Single NAND
    push(8'h3F, 2'd0, 1'b1);
    send(3'd2, 8'hF0, 8'hCC, 1'b0);
    drain();

    // All ops back-to-back
    push(8'h24, 0, 1); push(8'hBD, 0, 1); push(8'hDB, 0, 1); push(8'h42, 0, 1);
    push(8'h99, 0, 1); push(8'h66, 0, 1); push(8'h5A, 0, 1); push(8'hA5, 0, 1);
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(3'(i), 8'hA5, 8'h3C, 1'b0);
    chk("b2b_cycles", 64'(cyc - c0), 64'd8);
    drain();

    // NAND sweep, free-running consumer
    push(8'hFF, 2'd0, 1'b0); push(8'hFF, 2'd1, 1'b0);
    push(8'hFF, 2'd2, 1'b0); push(8'h00, 2'd3, 1'b1);
    send(3'd2, 8'h12, 8'h34, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sweep_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    drain();

    // XOR sweep with toggling consumer; inputs scrambled mid-sweep
    out_ready = 1'b0;
    push(8'h00, 2'd0, 1'b0); push(8'hFF, 2'd1, 1'b0);
    push(8'hFF, 2'd2, 1'b0); push(8'h00, 2'd3, 1'b1);
    send(3'd4, 8'h00, 8'h00, 1'b1);
    in_op = 3'd0; in_a = 8'hFF; in_b = 8'h0F;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    drain();

    // Reset mid-sweep at row 2
    push(8'h00, 2'd0, 1'b0); push(8'h00, 2'd1, 1'b0);
    push(8'h00, 2'd2, 1'b0); push(8'hFF, 2'd3, 1'b1);
    send(3'd0, 8'h00, 8'h00, 1'b1);
    t = 0;
    while (!(out_valid && out_row == 2'd2) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("reached_row2", 64'(out_row), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd0);
    chk("midrst_out_row",   64'(out_row),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    push(8'h99, 2'd0, 1'b1);
    send(3'd4, 8'hA5, 8'h3C, 1'b0);
    drain();

    // Stall, then simultaneous handshake and accept
    out_ready = 1'b0;
    push(8'h24, 2'd0, 1'b1);
    send(3'd0, 8'hA5, 8'h3C, 1'b0);
    push(8'hBD, 2'd0, 1'b1);
    in_valid = 1'b1; in_op = 3'd1; in_a = 8'hA5; in_b = 8'h3C; in_sweep = 1'b0;
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("stall_in_ready2", 64'(in_ready), 64'd0);
    chk("stall_out_y",     64'(out_y),    64'h24);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("reload_out_y", 64'(out_y), 64'hBD);
    drain();

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
